// File: rtl/collatz_range_engine.sv
// Collatz sequence-length engine: computes lengths for a block of consecutive
// start values, one iteration per clock, and serves them back from a RAM.
module collatz_range_engine #(
  parameter int RAM_WORDS     = 256,
  parameter int RAM_ADDR_BITS = 8,
  parameter int N_BITS        = 32,
  parameter int COUNT_BITS    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  input  logic [N_BITS-1:0]     start,
  output logic                  done,
  output logic [COUNT_BITS-1:0] count
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ITER,
    WRITE,
    DONE
  } state_t;

  localparam logic [COUNT_BITS-1:0]    LEN_MAX  = '1;
  localparam logic [RAM_ADDR_BITS-1:0] LAST_IDX = RAM_ADDR_BITS'(RAM_WORDS - 1);

  state_t                   state;
  state_t                   state_next;
  logic                     go_q;
  logic                     trigger;
  logic [N_BITS-1:0]        base;
  logic [N_BITS-1:0]        n;
  logic [N_BITS-1:0]        sum;
  logic [N_BITS-1:0]        n_step;
  logic [COUNT_BITS-1:0]    len;
  logic [RAM_ADDR_BITS-1:0] idx;
  logic [RAM_ADDR_BITS-1:0] rd_addr;
  logic                     iter_stop;
  logic                     last_word;
  logic [COUNT_BITS-1:0]    ram [RAM_WORDS];

  assign trigger   = go & ~go_q;
  assign sum       = base + N_BITS'(idx);
  assign iter_stop = (n == N_BITS'(1)) || (len == LEN_MAX);
  assign last_word = (idx == LAST_IDX);
  assign n_step    = n[0] ? (n + (n << 1) + N_BITS'(1)) : (n >> 1);

  // Read indices beyond the stored block wrap around onto it.
  assign rd_addr = RAM_ADDR_BITS'(int'(start[RAM_ADDR_BITS-1:0]) % RAM_WORDS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (trigger) state_next = LOAD;
      LOAD:       state_next = (sum == '0) ? WRITE : ITER;
      ITER:       if (iter_stop) state_next = WRITE;
      WRITE:      state_next = last_word ? DONE : LOAD;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      go_q  <= 1'b0;
      base  <= '0;
      idx   <= '0;
      n     <= '0;
      len   <= '0;
      done  <= 1'b0;
      count <= '0;
    end else begin
      go_q  <= go;
      count <= (state == DONE) ? ram[rd_addr] : '0;
      case (state)
        IDLE, DONE: begin
          if (trigger) begin
            base <= start;
            idx  <= '0;
            done <= 1'b0;
          end
        end
        LOAD: begin
          n   <= sum;
          len <= (sum == '0) ? '0 : COUNT_BITS'(1);
        end
        ITER: begin
          if (!iter_stop) begin
            n   <= n_step;
            len <= len + COUNT_BITS'(1);
          end
        end
        WRITE: begin
          if (last_word) begin
            done <= 1'b1;
          end else begin
            idx <= idx + RAM_ADDR_BITS'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // The result RAM is deliberately not reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (state == WRITE) begin
      ram[idx] <= len;
    end
  end

endmodule

// File: tb/tb_collatz_range_engine.sv
// Randomised scoreboard bench for collatz_range_engine against a plain
// arithmetic Collatz model; uses a narrow count width so saturation occurs.
module tb_collatz_range_engine;

  localparam int RW      = 8;
  localparam int AB      = 4;
  localparam int NB      = 32;
  localparam int CB      = 7;
  localparam int LEN_MAX = (1 << CB) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          go;
  logic [NB-1:0] start;
  logic          done;
  logic [CB-1:0] count;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_q[$];
  int   model_ram[RW];
  logic rd_tag   = 1'b0;
  logic rd_tag_q = 1'b0;

  collatz_range_engine #(
    .RAM_WORDS    (RW),
    .RAM_ADDR_BITS(AB),
    .N_BITS       (NB),
    .COUNT_BITS   (CB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .go   (go),
    .start(start),
    .done (done),
    .count(count)
  );

  always #10 clk = ~clk;

  // Sequence length straight from the definition, with saturation.
  function automatic int ref_len(logic [NB-1:0] v);
    longint unsigned x;
    int steps;
    x = 64'(v);
    if (x == 0) return 0;
    steps = 1;
    while (x != 1 && steps < LEN_MAX) begin
      if (x % 2 == 0) x = x / 2;
      else x = (3 * x + 1) % (64'd1 << NB);
      steps++;
    end
    return steps;
  endfunction

  task automatic check_output(string name, logic [63:0] actual, logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: a read issued before an edge shows up on count after that edge.
  always @(posedge clk) rd_tag_q <= rd_tag;

  always @(negedge clk) begin
    if (rd_tag_q) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL read_unexpected: got %0d with no expected value queued", count);
      end else begin
        check_output("read_data", 64'(count), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic read_index(int ridx);
    @(negedge clk);
    start  = NB'(ridx);
    rd_tag = 1'b1;
    exp_q.push_back(model_ram[ridx % RW]);
  endtask

  task automatic end_reads();
    @(negedge clk);
    rd_tag = 1'b0;
  endtask

  // mode 0 plain, 1 extra go pulse mid-run, 2 go rises on last WRITE, 3 go held.
  task automatic apply_stimulus(logic [NB-1:0] base, int mode);
    int lens[RW];
    int total;
    int cycles;
    int limit;
    int bad;
    int held_exp;
    total  = 0;
    cycles = 0;
    for (int i = 0; i < RW; i++) begin
      lens[i] = ref_len(base + NB'(i));
      total  += (lens[i] == 0) ? 2 : lens[i] + 2;
    end
    limit = total + 50;
    go = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = base;
    go    = 1'b1;
    @(posedge clk);
    while (cycles < limit) begin
      @(posedge clk);
      cycles++;
      #1;
      if (cycles == 1) begin
        check_output("run_done_low", 64'(done), 64'(0));
        check_output("run_count_zero", 64'(count), 64'(0));
        if (mode != 3) go = 1'b0;
      end
      if (done) break;
      if (mode == 1 && cycles == total / 2) go = 1'b1;
      if (mode == 1 && cycles == total / 2 + 1) go = 1'b0;
      if (mode == 2 && cycles == total - 1) go = 1'b1;
    end
    check_output("done_latency", 64'(cycles), 64'(total));
    for (int i = 0; i < RW; i++) model_ram[i] = lens[i];
    if (mode == 2) begin
      repeat (5) @(posedge clk);
      #1;
      check_output("late_trigger_ignored", 64'(done), 64'(1));
      go = 1'b0;
    end
    if (mode == 3) begin
      bad      = 0;
      held_exp = model_ram[2];
      @(negedge clk);
      start = NB'(2);
      @(negedge clk);
      repeat (100) begin
        @(negedge clk);
        if (done !== 1'b1 || count !== CB'(held_exp)) bad++;
      end
      check_output("held_go_bad_cycles", 64'(bad), 64'(0));
      go = 1'b0;
    end
  endtask

  initial begin
    #4_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    go    = 1'b0;
    start = '0;
    #35;
    check_output("reset_done", 64'(done), 64'(0));
    check_output("reset_count", 64'(count), 64'(0));
    @(negedge clk);
    reset = 1'b0;

    apply_stimulus(NB'(1), 0);
    for (int i = 0; i < RW; i++) read_index(i);
    read_index(9);
    read_index(15);
    end_reads();

    apply_stimulus(NB'(0), 1);
    read_index(0);
    read_index(1);
    read_index(3);
    end_reads();

    apply_stimulus(NB'(27), 2);
    read_index(0);
    read_index(4);
    end_reads();

    apply_stimulus(NB'(871), 0);
    read_index(0);
    read_index(6);
    end_reads();

    apply_stimulus(32'hFFFF_FFFD, 0);
    for (int i = 0; i < RW; i++) read_index(i);
    end_reads();

    apply_stimulus(NB'(5), 3);

    // Reset while results are being displayed clears outputs without a clock edge.
    @(negedge clk);
    start = NB'(2);
    @(posedge clk);
    #1;
    check_output("done_read_before_reset", 64'(count), 64'(model_ram[2]));
    #4 reset = 1'b1;
    #1;
    check_output("async_reset_done", 64'(done), 64'(0));
    check_output("async_reset_count", 64'(count), 64'(0));
    #5 reset = 1'b0;

    // Reset in the middle of a long iteration, then a fresh run.
    @(negedge clk);
    start = NB'(27);
    go    = 1'b1;
    repeat (6) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check_output("midrun_reset_done", 64'(done), 64'(0));
    check_output("midrun_reset_count", 64'(count), 64'(0));
    go = 1'b0;
    #6 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("idle_after_reset", 64'(done), 64'(0));

    apply_stimulus(NB'(6), 0);
    read_index(0);
    read_index(1);
    end_reads();

    repeat (6) begin
      logic [NB-1:0] b;
      b = ($urandom % 2 == 0) ? NB'($urandom) : NB'($urandom_range(0, 2000));
      apply_stimulus(b, 0);
      repeat (4) read_index(int'($urandom_range(0, 15)));
      end_reads();
    end

    @(negedge clk);
    @(negedge clk);
    check_output("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
